bullet_ctrl: RTL and testbench

Downstream consumer of the player stage. It takes the player's top-left position and facing direction plus the keyboard keycode, and spawns, moves and retires a small pool of projectiles on the frame tick. It provides a per-pixel hit flag for the colour mapper and a fire pulse for sound and score logic. All coordinates are in the 320x240 game space.

---
 rtl/bullet_ctrl.sv | 147 ++++++++++++++
 tb/tb_bullet_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
// Projectile pool: spawns bullets from the player centre on the frame tick, moves
// and retires them, and reports per-pixel hits, a fire pulse and the active count.
module bullet_ctrl #(
   parameter int NUM_BULLETS = 4,
   parameter int BULLET_STEP = 4,
   parameter int COOLDOWN    = 8,
   parameter int BULLET_SIZE = 2,
   parameter int FIRE_KEY    = 44,
   parameter int PLAYER_W    = 18,
   parameter int PLAYER_H    = 20,
   parameter int X_MAX       = 319,
   parameter int Y_MAX       = 239
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic [8:0] Player_X,
   input  logic [8:0] Player_Y,
   input  logic [1:0] Player_Dir,
   input  logic [8:0] PixelX,
   input  logic [8:0] PixelY,
   output logic       is_bullet,
   output logic       fire_event,
   output logic [3:0] active_count
);
   localparam int         CW       = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam logic [9:0] STEP10   = 10'(BULLET_STEP);
   localparam logic [9:0] SIZE10   = 10'(BULLET_SIZE);
   localparam logic [9:0] X_LIM    = 10'(X_MAX + 1 - BULLET_SIZE);
   localparam logic [9:0] Y_LIM    = 10'(Y_MAX + 1 - BULLET_SIZE);
   localparam logic [8:0] STEP9    = 9'(BULLET_STEP);
   localparam logic [8:0] SPAWN_DX = 9'(PLAYER_W / 2 - 1);
   localparam logic [8:0] SPAWN_DY = 9'(PLAYER_H / 2 - 1);

   logic [NUM_BULLETS-1:0] r_active, w_active;
   logic [8:0]             r_x   [NUM_BULLETS];
   logic [8:0]             r_y   [NUM_BULLETS];
   logic [1:0]             r_dir [NUM_BULLETS];
   logic [8:0]             w_x   [NUM_BULLETS];
   logic [8:0]             w_y   [NUM_BULLETS];
   logic [1:0]             w_dir [NUM_BULLETS];
   logic [CW-1:0]          r_cooldown, w_cooldown;
   logic                   r_frame_clk_d, r_frame_tick, r_fire_event;
   logic                   w_fire_req, w_spawned, w_hit;
   logic [3:0]             w_count;

   // Next pool state for a tick: move, retire against the old position, then spawn.
   always_comb begin
      w_active   = r_active;
      w_x        = r_x;
      w_y        = r_y;
      w_dir      = r_dir;
      w_spawned  = 1'b0;
      w_fire_req = (keycode == 8'(FIRE_KEY)) && (r_cooldown == {CW{1'b0}});
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (r_active[i]) begin
            case (r_dir[i])
               2'd0: begin
                  if (({1'b0, r_y[i]} + STEP10) > Y_LIM) w_active[i] = 1'b0;
                  else                                   w_y[i] = r_y[i] + STEP9;
               end
               2'd1: begin
                  if ({1'b0, r_x[i]} < STEP10) w_active[i] = 1'b0;
                  else                         w_x[i] = r_x[i] - STEP9;
               end
               2'd2: begin
                  if ({1'b0, r_y[i]} < STEP10) w_active[i] = 1'b0;
                  else                         w_y[i] = r_y[i] - STEP9;
               end
               2'd3: begin
                  if (({1'b0, r_x[i]} + STEP10) > X_LIM) w_active[i] = 1'b0;
                  else                                   w_x[i] = r_x[i] + STEP9;
               end
               default: w_active[i] = 1'b0;
            endcase
         end else begin
            w_active[i] = 1'b0;
         end
      end
      // Lowest free slot wins, including one freed by a retire this tick.
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (w_fire_req && !w_spawned && !w_active[i]) begin
            w_active[i] = 1'b1;
            w_x[i]      = Player_X + SPAWN_DX;
            w_y[i]      = Player_Y + SPAWN_DY;
            w_dir[i]    = Player_Dir;
            w_spawned   = 1'b1;
         end else begin
            w_spawned   = w_spawned;
         end
      end
      if (w_spawned)                           w_cooldown = CW'(COOLDOWN);
      else if (r_cooldown != {CW{1'b0}})       w_cooldown = r_cooldown - CW'(1);
      else                                     w_cooldown = r_cooldown;
   end

   // Frame-edge detection and tick-gated pool update.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_active      <= {NUM_BULLETS{1'b0}};
         for (int i = 0; i < NUM_BULLETS; i++) begin
            r_x[i]   <= 9'd0;
            r_y[i]   <= 9'd0;
            r_dir[i] <= 2'd0;
         end
         r_cooldown    <= {CW{1'b0}};
         r_frame_clk_d <= 1'b0;
         r_frame_tick  <= 1'b0;
         r_fire_event  <= 1'b0;
      end else begin
         r_frame_clk_d <= frame_clk;
         r_frame_tick  <= frame_clk & ~r_frame_clk_d;
         if (r_frame_tick) begin
            r_active     <= w_active;
            r_x          <= w_x;
            r_y          <= w_y;
            r_dir        <= w_dir;
            r_cooldown   <= w_cooldown;
            r_fire_event <= w_spawned;
         end else begin
            r_fire_event <= 1'b0;
         end
      end
   end

   // Pixel hit test and active-slot population count.
   always_comb begin
      w_hit   = 1'b0;
      w_count = 4'd0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         w_count = w_count + {3'b000, r_active[i]};
         if (r_active[i] &&
             ({1'b0, PixelX} >= {1'b0, r_x[i]}) && ({1'b0, PixelX} < ({1'b0, r_x[i]} + SIZE10)) &&
             ({1'b0, PixelY} >= {1'b0, r_y[i]}) && ({1'b0, PixelY} < ({1'b0, r_y[i]} + SIZE10))) begin
            w_hit = 1'b1;
         end else begin
            w_hit = w_hit;
         end
      end
   end

   assign is_bullet    = w_hit;
   assign active_count = w_count;
   assign fire_event   = r_fire_event;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl: a vector table for single-tick behaviour plus
// hand-written sequences for cooldown, pool exhaustion, boundaries and reset.
module tb_bullet_ctrl;
   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode = 8'd0;
   logic [8:0] Player_X = 9'd0, Player_Y = 9'd0, PixelX = 9'd0, PixelY = 9'd0;
   logic [1:0] Player_Dir = 2'd0;
   logic       is_bullet, fire_event;
   logic [3:0] active_count;

   int n_vec = 0;
   int n_err = 0;
   logic fired;

   typedef struct {
      logic [7:0] key;
      logic [8:0] plx, ply;
      logic [1:0] dir;
      logic [8:0] prx, pry;
      logic       exp_fire;
      logic [3:0] exp_cnt;
      logic       exp_hit;
   } vec_t;
   vec_t tbl [6];

   bullet_ctrl dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
      .Player_X(Player_X), .Player_Y(Player_Y), .Player_Dir(Player_Dir),
      .PixelX(PixelX), .PixelY(PixelY), .is_bullet(is_bullet),
      .fire_event(fire_event), .active_count(active_count)
   );

   always #10 Clk = ~Clk;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      frame_clk = 1'b0;
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   // One frame_clk rise; fired holds fire_event on the update cycle.
   task automatic do_tick();
      frame_clk = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      fired = fire_event;
      frame_clk = 1'b0;
      @(negedge Clk);
      check("fire_width", int'(fire_event), 0);
   endtask

   task automatic probe(input string name, input int x, input int y, input int exp);
      PixelX = 9'(x);
      PixelY = 9'(y);
      #1;
      check(name, int'(is_bullet), exp);
   endtask

   initial begin
      tbl[0] = '{8'd44, 9'd151, 9'd110, 2'd3, 9'd159, 9'd119, 1'b1, 4'd1, 1'b1};
      tbl[1] = '{8'd0,  9'd151, 9'd110, 2'd3, 9'd163, 9'd119, 1'b0, 4'd1, 1'b1};
      tbl[2] = '{8'd0,  9'd151, 9'd110, 2'd3, 9'd166, 9'd119, 1'b0, 4'd1, 1'b0};
      tbl[3] = '{8'd26, 9'd151, 9'd110, 2'd3, 9'd171, 9'd119, 1'b0, 4'd1, 1'b1};
      tbl[4] = '{8'd44, 9'd151, 9'd110, 2'd0, 9'd175, 9'd120, 1'b0, 4'd1, 1'b1};
      tbl[5] = '{8'd44, 9'd151, 9'd110, 2'd0, 9'd179, 9'd118, 1'b0, 4'd1, 1'b0};

      do_reset();
      check("reset_count", int'(active_count), 0);
      check("reset_fire", int'(fire_event), 0);
      probe("reset_hit", 0, 0, 0);

      for (int v = 0; v < 6; v++) begin
         keycode = tbl[v].key;
         Player_X = tbl[v].plx;
         Player_Y = tbl[v].ply;
         Player_Dir = tbl[v].dir;
         do_tick();
         check($sformatf("vec%0d_fire", v), int'(fired), int'(tbl[v].exp_fire));
         check($sformatf("vec%0d_count", v), int'(active_count), int'(tbl[v].exp_cnt));
         probe($sformatf("vec%0d_hit", v), int'(tbl[v].prx), int'(tbl[v].pry), int'(tbl[v].exp_hit));
      end

      // Cooldown spacing and full pool with slot reuse after a retire.
      do_reset();
      keycode = 8'd44; Player_X = 9'd151; Player_Y = 9'd110; Player_Dir = 2'd2;
      for (int t = 0; t < 40; t++) begin
         int exp_cnt;
         int sp [5];
         sp = '{0, 9, 18, 27, 36};
         exp_cnt = 0;
         foreach (sp[k]) if (sp[k] <= t && t < sp[k] + 30) exp_cnt++;
         do_tick();
         check($sformatf("pool_fire_t%0d", t), int'(fired), (t % 9 == 0 && t <= 36) ? 1 : 0);
         check($sformatf("pool_count_t%0d", t), int'(active_count), exp_cnt);
         if (t == 29) probe("pool_slot0_y3", 159, 3, 1);
      end

      // Right-edge retire; Player_Dir changes in flight must not steer the bullet.
      do_reset();
      keycode = 8'd44; Player_X = 9'd306; Player_Y = 9'd50; Player_Dir = 2'd3;
      do_tick();
      check("edge_spawn", int'(fired), 1);
      probe("edge_at314", 314, 59, 1);
      keycode = 8'd0; Player_Dir = 2'd1;
      do_tick();
      check("edge_count318", int'(active_count), 1);
      probe("edge_at318", 319, 59, 1);
      do_tick();
      check("edge_retired", int'(active_count), 0);
      probe("edge_gone", 319, 59, 0);

      // Pixel sweep around a bullet at (100,50).
      do_reset();
      keycode = 8'd44; Player_X = 9'd92; Player_Y = 9'd41; Player_Dir = 2'd0;
      do_tick();
      keycode = 8'd0;
      for (int px = 98; px <= 103; px++)
         for (int py = 48; py <= 53; py++)
            probe($sformatf("sweep_%0d_%0d", px, py), px, py,
                  ((px == 100 || px == 101) && (py == 50 || py == 51)) ? 1 : 0);

      // Asynchronous reset with three bullets in flight.
      do_reset();
      keycode = 8'd44; Player_X = 9'd151; Player_Y = 9'd200; Player_Dir = 2'd2;
      for (int t = 0; t < 19; t++) do_tick();
      keycode = 8'd0;
      check("arst_pre_count", int'(active_count), 3);
      probe("arst_pre_hit", 159, 209, 1);
      @(negedge Clk);
      #3 Reset = 1'b1;
      #1;
      check("arst_count", int'(active_count), 0);
      check("arst_hit", int'(is_bullet), 0);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      keycode = 8'd44;
      do_tick();
      check("arst_refire", int'(fired), 1);
      check("arst_refire_count", int'(active_count), 1);
      probe("arst_refire_hit", 159, 209, 1);

      // Non-fire keycode never spawns.
      do_reset();
      keycode = 8'd26;
      for (int t = 0; t < 5; t++) begin
         do_tick();
         check($sformatf("wrongkey_fire_t%0d", t), int'(fired), 0);
         check($sformatf("wrongkey_count_t%0d", t), int'(active_count), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
